rst_seq_ctrl: RTL

- Reset sequencer for the multi-clock system. Runs in the always-on reference domain.
- Releases per-domain reset requests one at a time, in index order (0 first). Each DOM_RST_N bit drives the RST input of that domain's reset synchronizer.
- Waits for the domain's synchronized-reset acknowledge before releasing the next domain.
- Also handles software-requested re-reset, ack timeouts and loss of ack after bring-up.

---
 rtl/parameters_pkg.sv | 16 +
 rtl/bit_sync.sv | 29 ++
 rtl/rst_seq_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/parameters_pkg.sv
// rtl/parameters_pkg.sv - shared state encoding and default sizes for the reset sequencer
package parameters_pkg;

    typedef enum logic [2:0] {
        HOLD,
        RELEASE,
        WAIT_ACK,
        DONE,
        ASSERT,
        FAULT
    } rst_seq_state_e;

    localparam int DEF_N_DOM = 3;
    localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/bit_sync.sv
// rtl/bit_sync.sv - WIDTH-bit multi-flop synchronizer, async active-low reset to 0
module bit_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int s = 0; s < STAGES; s++) begin
                stage_q[s] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int s = 1; s < STAGES; s++) begin
                stage_q[s] <= stage_q[s-1];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// rtl/rst_seq_ctrl.sv - in-order per-domain reset release sequencer with ack supervision
// RST_SEQ_REVERSE_ASSERT_EN: drop domains one by one, highest index first, when re-asserting.
module rst_seq_ctrl
    import parameters_pkg::*;
#(
    parameter int N_DOM       = DEF_N_DOM,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int RELEASE_DLY = 16,
    parameter int ACK_TIMEOUT = 200,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       SW_RST_REQ,
    input  logic [N_DOM-1:0]           DOM_ACK,
    output logic [N_DOM-1:0]           DOM_RST_N,
    output logic                       ALL_READY,
    output logic                       SEQ_ERR,
    output logic [$clog2(N_DOM)-1:0]   CUR_DOM
);

    localparam int DOM_W = $clog2(N_DOM);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RELEASE_DLY - 1);
    localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [DOM_W-1:0] LAST_DOM  = DOM_W'(N_DOM - 1);
    localparam logic [DOM_W-1:0] DOM_ONE   = DOM_W'(1);

    rst_seq_state_e   state;
    logic [CNT_W-1:0] cnt;
    logic [N_DOM-1:0] ack_s;
    logic             ack_lost;
    logic             start_assert;
    logic             drop_busy;

    bit_sync #(
        .WIDTH  (N_DOM),
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .CLK (CLK),
        .RST (RST),
        .d   (DOM_ACK),
        .q   (ack_s)
    );

    // Software request outranks everything, including the loss-of-ack it may coincide with.
    assign ack_lost     = (state == DONE) && !(&ack_s);
    assign start_assert = SW_RST_REQ || ack_lost;

`ifdef RST_SEQ_REVERSE_ASSERT_EN
    assign drop_busy = (state == ASSERT) && (DOM_RST_N != '0);
`else
    assign drop_busy = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= HOLD;
            cnt       <= '0;
            CUR_DOM   <= '0;
            DOM_RST_N <= '0;
            ALL_READY <= 1'b0;
            SEQ_ERR   <= 1'b0;
        end else if (start_assert) begin
            state     <= ASSERT;
            cnt       <= '0;
            ALL_READY <= 1'b0;
            SEQ_ERR   <= !SW_RST_REQ;
`ifdef RST_SEQ_REVERSE_ASSERT_EN
            CUR_DOM              <= LAST_DOM;
            DOM_RST_N[LAST_DOM]  <= 1'b0;
`else
            CUR_DOM   <= '0;
            DOM_RST_N <= '0;
`endif
        end else begin
            case (state)
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt   <= '0;
                        state <= RELEASE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                RELEASE: begin
                    DOM_RST_N[CUR_DOM] <= 1'b1;
                    cnt                <= '0;
                    state              <= WAIT_ACK;
                end

                WAIT_ACK: begin
                    if (ack_s[CUR_DOM]) begin
                        if (CUR_DOM == LAST_DOM) begin
                            state     <= DONE;
                            ALL_READY <= 1'b1;
                        end else begin
                            CUR_DOM <= CUR_DOM + DOM_ONE;
                            cnt     <= '0;
                            state   <= HOLD;
                        end
                    end else if (cnt == ACK_LAST) begin
                        SEQ_ERR   <= 1'b1;
                        DOM_RST_N <= '0;
                        state     <= FAULT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DONE: begin
                    ALL_READY <= 1'b1;
                end

                ASSERT: begin
                    ALL_READY <= 1'b0;
`ifndef RST_SEQ_REVERSE_ASSERT_EN
                    DOM_RST_N <= '0;
                    CUR_DOM   <= '0;
`endif
                    if (drop_busy) begin
`ifdef RST_SEQ_REVERSE_ASSERT_EN
                        // Staged drop; the ack timeout only starts once bit 0 is down.
                        if (cnt == HOLD_LAST) begin
                            cnt <= '0;
                            if (CUR_DOM != '0) begin
                                CUR_DOM                      <= CUR_DOM - DOM_ONE;
                                DOM_RST_N[CUR_DOM - DOM_ONE] <= 1'b0;
                            end else begin
                                DOM_RST_N <= '0;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
`endif
                    end else if (ack_s == '0) begin
                        cnt   <= '0;
                        state <= HOLD;
                    end else if (cnt == ACK_LAST) begin
                        SEQ_ERR <= 1'b1;
                        state   <= FAULT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                FAULT: begin
                    DOM_RST_N <= '0;
                    ALL_READY <= 1'b0;
                end

                default: begin
                    state <= HOLD;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
